// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, sequencer state encoding and opcode class helpers
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOT = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1001;
    localparam logic [3:0] OP_ROR = 4'b1010;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_ROR;
    endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// rtl/alu_settle_counter.sv - loadable down-counter that flags the final settle cycle
module alu_settle_counter
    import alu_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && !load && (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - ALU issue sequencer: operand regs, settle wait, result capture, HI/LO
// Optional macro ALU_ILLEGAL_TRAP_EN: illegal opcodes bypass the ALU and report op_err.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int ALU_CYCLES    = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        z_zero,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg,
    output logic        op_err
);

    localparam logic [CNT_W-1:0] ALU_LOAD    = CNT_W'(ALU_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    seq_state_t  state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [31:0] z_hi_q, z_hi_d;
    logic [31:0] z_lo_q, z_lo_d;
    logic        z_zero_q, z_zero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic        op_err_q, op_err_d;
`endif

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_done;

    alu_settle_counter #(.W(CNT_W)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        z_hi_d       = z_hi_q;
        z_lo_d       = z_lo_q;
        z_zero_d     = z_zero_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
`ifdef ALU_ILLEGAL_TRAP_EN
        op_err_d     = op_err_q;
`endif
        cnt_load     = 1'b0;
        cnt_load_val = ALU_LOAD;
        cnt_en       = (state_q == ST_EXEC);

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    alu_op_d    = req_op;
                    alu_a_d     = req_a;
                    alu_b_d     = req_b;
                    req_ready_d = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
                    if (is_illegal(req_op)) begin
                        state_d     = ST_HOLD;
                        z_hi_d      = '0;
                        z_lo_d      = '0;
                        z_zero_d    = 1'b1;
                        op_err_d    = 1'b1;
                        rsp_valid_d = 1'b1;
                    end else begin
`else
                    begin
`endif
                        state_d      = ST_EXEC;
                        cnt_load     = 1'b1;
                        cnt_load_val = is_muldiv(req_op) ? MULDIV_LOAD : ALU_LOAD;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_done) begin
                    z_hi_d      = alu_result[63:32];
                    z_lo_d      = alu_result[31:0];
                    z_zero_d    = alu_zero;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                    // DIV packs remainder in the upper word, so both ops map identically
                    if (is_muldiv(alu_op_q)) begin
                        hi_d = alu_result[63:32];
                        lo_d = alu_result[31:0];
                    end
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
`ifdef ALU_ILLEGAL_TRAP_EN
                    op_err_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            z_hi_q      <= '0;
            z_lo_q      <= '0;
            z_zero_q    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
`ifdef ALU_ILLEGAL_TRAP_EN
            op_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            z_hi_q      <= z_hi_d;
            z_lo_q      <= z_lo_d;
            z_zero_q    <= z_zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
`ifdef ALU_ILLEGAL_TRAP_EN
            op_err_q    <= op_err_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign z_hi      = z_hi_q;
    assign z_lo      = z_lo_q;
    assign z_zero    = z_zero_q;
    assign hi_reg    = hi_q;
    assign lo_reg    = lo_q;
`ifdef ALU_ILLEGAL_TRAP_EN
    assign op_err    = op_err_q;
`else
    assign op_err    = 1'b0;
`endif

endmodule
